// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode, fetch-state and reset-vector constants shared by the fetch front end
package riscv_pkg;
  localparam logic [4:0] OP_JAL = 5'b11011;
  localparam logic [4:0] OP_JALR = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0004;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_e;
endpackage

// File: rtl/branch_target_gen.sv
// branch_target_gen: redirect target and misalignment flag for the EX instruction
module branch_target_gen
  import riscv_pkg::*;
(
  input  logic [4:0]  opcode,
  input  logic [31:0] ex_pc,
  input  logic [31:0] rs1,
  input  logic [31:0] imm,
  output logic [31:0] target,
  output logic        misaligned
);
  assign target = opcode == OP_JALR ? (rs1 + imm) & ~32'h1 : ex_pc + imm;
  assign misaligned = target[1];
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: fetch PC sequencer with branch redirect and stale-response drop
module branch_redirect_ctrl
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC,
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             branch_taken_in,
  input  logic             ex_valid_in,
  input  logic [31:0]      ex_pc_in,
  input  logic [31:0]      imm_in,
  input  logic [31:0]      rs1_in,
  input  logic [4:0]       opcode_6_2_in,
  input  logic             stall_in,
  output logic             imem_req_out,
  output logic [31:0]      imem_addr_out,
  input  logic             imem_gnt_in,
  input  logic             imem_rvalid_in,
  output logic             if_valid_out,
  output logic [31:0]      if_pc_out,
  output logic             flush_out,
  output logic             misaligned_exc_out,
  output logic [31:0]      misaligned_addr_out,
  output logic [CNT_W-1:0] redirect_cnt_out
);
  fetch_state_e state, state_d;
  logic [31:0] pc, pc_d, target, eff_target;
  logic misaligned, redir;
  branch_target_gen u_tgt (
    .opcode(opcode_6_2_in),
    .ex_pc(ex_pc_in),
    .rs1(rs1_in),
    .imm(imm_in),
    .target(target),
    .misaligned(misaligned)
  );
  assign redir = ex_valid_in & branch_taken_in & ~stall_in;
  assign eff_target = misaligned ? TRAP_VEC : target;
  assign flush_out = redir;
  assign misaligned_exc_out = redir & misaligned;
  assign imem_req_out = state == REQ && !stall_in;
  assign imem_addr_out = pc;
  assign if_valid_out = state == WAIT && imem_rvalid_in && !redir;
  assign if_pc_out = pc;
  always_comb begin
    state_d = state;
    pc_d = redir ? eff_target : pc;
    case (state)
      IDLE: state_d = REQ;
      REQ: state_d = redir ? (imem_gnt_in ? DROP : REQ) : (imem_gnt_in && !stall_in ? WAIT : REQ);
      WAIT: begin
        pc_d = if_valid_out ? pc + 32'd4 : pc_d;
        state_d = imem_rvalid_in ? REQ : redir ? DROP : WAIT;
      end
      default: state_d = imem_rvalid_in ? REQ : DROP;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      pc <= RESET_PC;
      redirect_cnt_out <= '0;
      misaligned_addr_out <= '0;
    end else begin
      state <= state_d;
      pc <= pc_d;
      if (redir && !(&redirect_cnt_out)) redirect_cnt_out <= redirect_cnt_out + 1'b1;
      if (misaligned_exc_out) misaligned_addr_out <= target;
    end
  end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed fetch/redirect scenarios with hand-computed expectations
module tb_branch_redirect_ctrl;
  import riscv_pkg::*;
  logic clk = 0, rst_n = 0, taken = 0, ex_valid = 0, stall = 0, gnt = 0, rvalid = 0;
  logic [31:0] ex_pc = 0, imm = 0, rs1 = 0;
  logic [4:0] opcode = 0;
  logic req, if_valid, flush, mis_exc;
  logic [31:0] addr, if_pc, mis_addr;
  logic [3:0] cnt;
  int checks = 0, failures = 0;
  branch_redirect_ctrl #(.CNT_W(4)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .branch_taken_in(taken), .ex_valid_in(ex_valid),
    .ex_pc_in(ex_pc), .imm_in(imm), .rs1_in(rs1), .opcode_6_2_in(opcode), .stall_in(stall),
    .imem_req_out(req), .imem_addr_out(addr), .imem_gnt_in(gnt), .imem_rvalid_in(rvalid),
    .if_valid_out(if_valid), .if_pc_out(if_pc), .flush_out(flush),
    .misaligned_exc_out(mis_exc), .misaligned_addr_out(mis_addr), .redirect_cnt_out(cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic ex_set(input logic [4:0] op, input logic [31:0] pc_v, input logic [31:0] rs1_v, input logic [31:0] imm_v);
    ex_valid = 1; taken = 1; opcode = op; ex_pc = pc_v; rs1 = rs1_v; imm = imm_v;
  endtask
  task automatic ex_clr();
    ex_valid = 0; taken = 0;
  endtask
  initial begin
    tick(); tick();
    check("rst_req", req, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_flush", flush, 0);
    check("rst_mis_exc", mis_exc, 0);
    check("rst_cnt", cnt, 0);
    check("rst_mis_addr", mis_addr, 0);
    rst_n = 1; gnt = 1;
    tick();
    check("req0", req, 1);
    check("addr0", addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      rvalid = 1; settle();
      check("if_valid_seq", if_valid, 1);
      check("if_pc_seq", if_pc, 32'(i * 4));
      tick();
      rvalid = 0; settle();
      check("req_seq", req, 1);
      check("addr_seq", addr, 32'(i * 4 + 4));
    end
    tick();
    ex_set(OP_BRANCH, 32'h10, 0, 32'h20); settle();
    check("beq_flush", flush, 1);
    check("beq_if_valid", if_valid, 0);
    tick();
    ex_clr(); settle();
    check("drop_req", req, 0);
    check("beq_cnt", cnt, 1);
    rvalid = 1; settle();
    check("drop_discard", if_valid, 0);
    tick();
    rvalid = 0; settle();
    check("beq_addr", addr, 32'h30);
    check("beq_req", req, 1);
    ex_set(OP_JALR, 0, 32'h101, 32'h4); settle();
    check("jalr_flush", flush, 1);
    check("jalr_no_exc", mis_exc, 0);
    tick();
    ex_clr(); rvalid = 1; settle();
    check("jalr_drop", if_valid, 0);
    tick();
    rvalid = 0; settle();
    check("jalr_addr", addr, 32'h104);
    gnt = 0;
    ex_set(OP_JALR, 0, 32'h102, 32'h0); settle();
    check("mis_exc", mis_exc, 1);
    check("mis_flush", flush, 1);
    tick();
    ex_clr(); settle();
    check("trap_addr", addr, 32'h4);
    check("mis_addr", mis_addr, 32'h102);
    check("mis_exc_pulse", mis_exc, 0);
    check("mis_cnt", cnt, 3);
    stall = 1;
    ex_set(OP_BRANCH, 32'h40, 0, 32'h10); settle();
    check("stall_flush", flush, 0);
    check("stall_req", req, 0);
    tick();
    check("stall_addr", addr, 32'h4);
    check("stall_cnt", cnt, 3);
    stall = 0; settle();
    check("unstall_flush", flush, 1);
    tick();
    ex_clr(); settle();
    check("unstall_addr", addr, 32'h50);
    check("unstall_cnt", cnt, 4);
    gnt = 1;
    tick();
    gnt = 0; rvalid = 1;
    ex_set(OP_JAL, 32'h60, 0, 32'h100); settle();
    check("rv_redir_if_valid", if_valid, 0);
    check("rv_redir_flush", flush, 1);
    tick();
    ex_clr(); rvalid = 0; settle();
    check("rv_redir_req", req, 1);
    check("rv_redir_addr", addr, 32'h160);
    check("rv_redir_cnt", cnt, 5);
    ex_set(OP_JAL, 32'h200, 0, 32'h0);
    for (int i = 0; i < 9; i++) tick();
    check("cnt_14", cnt, 14);
    for (int i = 0; i < 3; i++) tick();
    check("cnt_sat", cnt, 4'hF);
    ex_set(OP_JAL, 32'hFFFF_FFF0, 0, 32'hC);
    tick();
    ex_clr(); settle();
    check("cnt_hold", cnt, 4'hF);
    check("wrap_addr", addr, 32'hFFFF_FFFC);
    gnt = 1;
    tick();
    gnt = 0; rvalid = 1; settle();
    check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    tick();
    rvalid = 0; settle();
    check("wrap_next", addr, 32'h0);
    gnt = 1;
    tick();
    check("wait_req", req, 0);
    gnt = 0; rst_n = 0;
    tick();
    rvalid = 1; settle();
    check("mrst_cnt", cnt, 0);
    check("mrst_mis_addr", mis_addr, 0);
    check("mrst_req", req, 0);
    check("mrst_if_valid", if_valid, 0);
    rst_n = 1;
    tick();
    rvalid = 0; settle();
    check("mrst_restart_req", req, 1);
    check("mrst_restart_addr", addr, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Fetch-side PC sequencer for the RV32 pipeline. It owns the fetch PC and issues requests on the instruction-memory req/gnt/rvalid handshake. It consumes the EX-stage branch decision and redirects fetch on taken branches and jumps, flushing younger stages. Any in-flight instruction-memory response made stale by a redirect is dropped.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
TRAP_VEC, 32'h0000_0004, redirect target on misaligned branch/jump target
CNT_W, 16, width of the saturating taken-redirect counter

Ports:
clk_in  input  1  core clock
rst_n_in  input  1  synchronous reset, active-low
branch_taken_in  input  1  EX-stage branch/jump taken decision
ex_valid_in  input  1  EX stage holds a valid instruction
ex_pc_in  input  32  PC of EX instruction
imm_in  input  32  sign-extended immediate of EX instruction
rs1_in  input  32  rs1 operand of EX instruction
opcode_6_2_in  input  5  EX opcode[6:2]: 11011 JAL, 11001 JALR, 11000 BRANCH
stall_in  input  1  pipeline stall; blocks new fetch requests and redirects
imem_req_out  output  1  instruction-memory request
imem_addr_out  output  32  request address, equals current fetch PC
imem_gnt_in  input  1  request accepted this cycle
imem_rvalid_in  input  1  response data valid, one per granted request, in order
if_valid_out  output  1  pulse: fetched instruction valid for IF/ID
if_pc_out  output  32  PC of the delivered instruction
flush_out  output  1  kill IF/ID and ID/EX at next edge
misaligned_exc_out  output  1  pulse: redirect target not 4-byte aligned
misaligned_addr_out  output  32  offending target, held until next exception
redirect_cnt_out  output  CNT_W  saturating count of accepted redirects

Behaviour:
- Reset: applied on the clock edge while rst_n_in=0. Sets state=IDLE, pc=RESET_PC, redirect_cnt_out=0, misaligned_addr_out=0. Reset mid-transaction abandons the transaction. The imem side shares the reset, so no stale response survives.
- Reset values of other outputs: imem_req_out, if_valid_out, flush_out and misaligned_exc_out are all 0.
- Redirect accepted (redir) = ex_valid_in & branch_taken_in & ~stall_in.
- Target selection:
  - JALR: (rs1_in+imm_in) & ~32'h1.
  - JAL/BRANCH: ex_pc_in+imm_in.
  - Additions are mod 2^32.
- Misaligned redirect: if redir and target[1]=1:
  - misaligned_exc_out pulses in the same cycle.
  - misaligned_addr_out <= target.
  - The effective target becomes TRAP_VEC.
- flush_out = redir, combinational, same cycle.
- redirect_cnt_out increments on redir and saturates at all-ones.
- FSM states:
  - IDLE: req=0. Next cycle goes to REQ.
  - REQ: imem_req_out = ~stall_in, addr=pc.
    - redir & gnt: pc<=target, go to DROP.
    - redir & ~gnt: pc<=target, stay in REQ.
    - gnt alone: go to WAIT.
  - WAIT: req=0.
    - rvalid & ~redir: if_valid_out=1, if_pc_out=pc, pc<=pc+4, go to REQ.
    - rvalid & redir: response discarded, pc<=target, go to REQ.
    - redir alone: pc<=target, go to DROP.
  - DROP: req=0.
    - rvalid: discard (if_valid_out=0), go to REQ.
    - redir: pc<=target, stay in DROP until rvalid.
- stall_in:
  - Gates only new request issue and redirect acceptance.
  - A response arriving in WAIT is delivered regardless; the IF/ID buffer holds it.
- One outstanding request maximum. rvalid in IDLE/REQ is a protocol error and is ignored.
- pc+4 wraps at 2^32.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode[6:2] constants OP_JAL, OP_JALR, OP_BRANCH;
  - fetch FSM state enum {IDLE, REQ, WAIT, DROP};
  - default RESET_PC/TRAP_VEC.
- One combinational sub-module, branch_target_gen, computes the target and the misaligned flag from opcode, ex_pc, rs1 and imm.
- FSM, PC register and counter stay in the top module.

Test Plan:
- Reset release, imem_gnt_in=1 always, rvalid one cycle after grant -> requests at 0x0, 0x4, 0x8; if_valid_out pulses with if_pc_out=0x0, 0x4, 0x8.
- BEQ taken in EX (ex_pc=0x10, imm=0x20) while in WAIT, no rvalid -> flush_out=1 that cycle, state DROP. Next rvalid discarded; next request addr=0x30; redirect_cnt_out=1.
- JALR with rs1=0x101, imm=0x4 -> target 0x104, redirect with no exception. rs1=0x102, imm=0 -> misaligned_exc_out=1, misaligned_addr_out=0x102, next request addr=TRAP_VEC.
- Redirect with stall_in=1 -> no flush, pc unchanged. Same branch after stall drops -> redirect accepted once.
- rvalid and redirect in the same WAIT cycle -> if_valid_out=0, next cycle REQ at target (no DROP).
- CNT_W=4, 17 redirects -> redirect_cnt_out saturates at 4'hF. rst_n_in=0 mid-WAIT -> all outputs cleared at next edge, fetch restarts at RESET_PC.
